// File: rtl/game_speed_governor.sv
// game_speed_governor: difficulty level, grace window, pause and play-frame counter for the game clock
module game_speed_governor #(
    parameter int KILLS_PER_LEVEL = 8,
    parameter int MAX_LEVEL       = 10,
    parameter int HOLD_TICKS      = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_tick,
    input  logic        start,
    input  logic        pause,
    input  logic        kill,
    input  logic        ship_hit,
    output logic [3:0]  speed_level,
    output logic        level_up,
    output logic [15:0] tick_count,
    output logic [1:0]  state
);
    localparam int KW = $clog2(KILLS_PER_LEVEL + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [KW-1:0] KMAX = KW'(KILLS_PER_LEVEL - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
    localparam logic [3:0] MAXL = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HOLD = 2'd2, PAUSED = 2'd3} state_t;

    state_t st, st_n, resume_state, rs_n;
    logic [3:0] lvl_n;
    logic up_n;
    logic [15:0] tc_n;
    logic [KW-1:0] kill_cnt, kc_n;
    logic [HW-1:0] hold_cnt, hc_n;

    assign state = st;

    // state and counter registers; reset aborts the game at once
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            resume_state <= PLAY;
            speed_level <= 4'd0;
            level_up <= 1'b0;
            tick_count <= 16'd0;
            kill_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            st <= st_n;
            resume_state <= rs_n;
            speed_level <= lvl_n;
            level_up <= up_n;
            tick_count <= tc_n;
            kill_cnt <= kc_n;
            hold_cnt <= hc_n;
        end
    end

    // next state: game_tick runs independently, then pause > ship_hit > kill
    always_comb begin
        st_n = st;
        rs_n = resume_state;
        lvl_n = speed_level;
        up_n = 1'b0;
        tc_n = tick_count;
        kc_n = kill_cnt;
        hc_n = hold_cnt;
        if (st == IDLE) begin
            if (start) begin
                st_n = PLAY;
                lvl_n = 4'd0;
                kc_n = '0;
                tc_n = 16'd0;
                hc_n = '0;
            end
        end else if (st == PAUSED) begin
            if (pause) st_n = resume_state;
        end else begin
            if (game_tick && tick_count != 16'hFFFF) tc_n = tick_count + 16'd1;
            if (st == HOLD && game_tick && hold_cnt != '0) begin
                hc_n = hold_cnt - 1'b1;
                if (hold_cnt == HW'(1)) st_n = PLAY;
            end
            if (pause) begin
                rs_n = st_n;
                st_n = PAUSED;
            end else if (ship_hit) begin
                lvl_n = (speed_level != 4'd0) ? speed_level - 4'd1 : 4'd0;
                kc_n = '0;
                hc_n = '0;
                st_n = PLAY;
            end else if (kill) begin
                if (st == HOLD) kc_n = (kill_cnt == KMAX) ? KMAX : kill_cnt + 1'b1;
                else if (kill_cnt == KMAX) begin
                    kc_n = '0;
                    if (speed_level < MAXL) begin
                        lvl_n = speed_level + 4'd1;
                        up_n = 1'b1;
                        hc_n = HOLD_INIT;
                        st_n = HOLD;
                    end
                end else kc_n = kill_cnt + 1'b1;
            end
        end
    end
endmodule
